// File: rtl/ps_pkg.sv
// Shared definitions for the 8-bit comma-aligned serial link (transmitter and receiver).
package ps_pkg;

  localparam int unsigned PS_BYTE_W = 8;
  localparam int unsigned PS_BIT_CNT_W = $clog2(PS_BYTE_W);
  localparam logic [PS_BYTE_W-1:0] PS_COMMA = 8'hBC;

  typedef enum logic [1:0] {
    StReset,
    StSync,
    StRun
  } ps_tx_state_t;

endpackage

// File: rtl/ps_bit_timer.sv
// Bit position counter within a byte slot; strobes load on the last bit or when forced.
module ps_bit_timer
  import ps_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    force_load,
  output logic [PS_BIT_CNT_W-1:0] bit_cnt,
  output logic                    load
);

  localparam logic [PS_BIT_CNT_W-1:0] BitLast = PS_BIT_CNT_W'(PS_BYTE_W - 1);

  logic [PS_BIT_CNT_W-1:0] bit_cnt_d, bit_cnt_q;

  always_comb begin
    load = force_load || (bit_cnt_q == BitLast);
    if (reset || load) begin
      bit_cnt_d = '0;
    end else begin
      bit_cnt_d = bit_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    bit_cnt_q <= bit_cnt_d;
  end

  assign bit_cnt = bit_cnt_q;

endmodule

// File: rtl/ps_tx_serializer.sv
// Parallel-to-serial transmitter: comma preamble, then MSB-first bytes with comma fill.
// Optional saturating byte_cnt port when PS_TX_BYTE_CNT_EN is defined.
module ps_tx_serializer
  import ps_pkg::*;
#(
  parameter int unsigned           SYNC_BYTES = 4,
  parameter logic [PS_BYTE_W-1:0] IDLE_BYTE  = PS_COMMA
) (
  input  logic                 clk_32f,
  input  logic                 reset,
  input  logic [PS_BYTE_W-1:0] data_in,
  input  logic                 valid_in,
  output logic                 ready_out,
  output logic                 data_out,
  output logic                 active_out
`ifdef PS_TX_BYTE_CNT_EN
  ,
  output logic [15:0]          byte_cnt
`endif
);

  localparam logic [3:0] SyncLast = 4'(SYNC_BYTES - 1);

  ps_tx_state_t state_d, state_q;
  logic [PS_BYTE_W-1:0] shift_d, shift_q;
  logic [3:0] sync_cnt_d, sync_cnt_q;
  logic [PS_BIT_CNT_W-1:0] bit_cnt;
  logic load;
  logic handshake;

  ps_bit_timer u_bit_timer (
    .clk        (clk_32f),
    .reset      (reset),
    .force_load (state_q == StReset),
    .bit_cnt    (bit_cnt),
    .load       (load)
  );

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state_q <= StReset;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StReset: state_d = (SYNC_BYTES == 1) ? StRun : StSync;
      StSync:  if (load && (sync_cnt_q == SyncLast)) state_d = StRun;
      StRun:   state_d = StRun;
      default: state_d = StReset;
    endcase
  end

  always_comb begin
    ready_out  = (state_q == StRun) && (bit_cnt == PS_BIT_CNT_W'(PS_BYTE_W - 1));
    active_out = (state_q == StRun);
  end

  assign handshake = valid_in && ready_out;

  always_comb begin
    shift_d    = {shift_q[PS_BYTE_W-2:0], 1'b0};
    sync_cnt_d = sync_cnt_q;
    if (load) begin
      unique case (state_q)
        StReset: begin
          shift_d    = IDLE_BYTE;
          sync_cnt_d = 4'd1;
        end
        StSync: begin
          shift_d    = IDLE_BYTE;
          sync_cnt_d = sync_cnt_q + 4'd1;
        end
        StRun:   shift_d = handshake ? data_in : IDLE_BYTE;
        default: shift_d = IDLE_BYTE;
      endcase
    end
  end

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      shift_q    <= '0;
      sync_cnt_q <= '0;
    end else begin
      shift_q    <= shift_d;
      sync_cnt_q <= sync_cnt_d;
    end
  end

  assign data_out = shift_q[PS_BYTE_W-1];

`ifdef PS_TX_BYTE_CNT_EN
  logic [15:0] byte_cnt_q;

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      byte_cnt_q <= '0;
    end else if (handshake && (byte_cnt_q != 16'hFFFF)) begin
      byte_cnt_q <= byte_cnt_q + 16'd1;
    end
  end

  assign byte_cnt = byte_cnt_q;
`endif

endmodule

// File: tb/tb_ps_tx_serializer.sv
// Directed bench for ps_tx_serializer (SYNC_BYTES=4 instance plus a SYNC_BYTES=1 instance).
module tb_ps_tx_serializer;

  logic       clk_32f = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_out, data_out, active_out;
  logic       ready1, data1, active1;
`ifdef PS_TX_BYTE_CNT_EN
  logic [15:0] byte_cnt, byte_cnt1;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] tx_q [4];

  always #5 clk_32f = ~clk_32f;

  ps_tx_serializer #(.SYNC_BYTES(4)) dut (
    .clk_32f    (clk_32f),
    .reset      (reset),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .data_out   (data_out),
    .active_out (active_out)
`ifdef PS_TX_BYTE_CNT_EN
    ,
    .byte_cnt   (byte_cnt)
`endif
  );

  ps_tx_serializer #(.SYNC_BYTES(1)) dut1 (
    .clk_32f    (clk_32f),
    .reset      (reset),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .ready_out  (ready1),
    .data_out   (data1),
    .active_out (active1)
`ifdef PS_TX_BYTE_CNT_EN
    ,
    .byte_cnt   (byte_cnt1)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk_32f);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready_out && n < 16) begin
      step();
      n++;
    end
    check("ready_timeout", ready_out, 1'b1);
  endtask

  // Release is assumed done; checks E1..E32 of the preamble on both instances.
  task automatic check_preamble();
    logic [7:0] rb;
    int i;
    rb = '0;
    for (int k = 1; k <= 32; k++) begin
      step();
      i = (k - 1) % 8;
      rb[7-i] = data_out;
      if (i == 7) check("preamble_byte", rb, 8'hBC);
      if (k == 24) check("active_pre_e25", active_out, 1'b0);
      if (k == 25) check("active_post_e25", active_out, 1'b1);
      if (k == 31) check("ready_pre_e32", ready_out, 1'b0);
      if (k == 32) check("ready_before_e33", ready_out, 1'b1);
      if (k == 1) begin
        check("s1_active_e1", active1, 1'b1);
        check("s1_data_e1", data1, 1'b1);
      end
      if (k == 7) check("s1_ready_e7", ready1, 1'b0);
      if (k == 8) check("s1_ready_before_e9", ready1, 1'b1);
    end
  endtask

  task automatic recv_byte(output logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      step();
      b[7-i] = data_out;
    end
  endtask

  // Sends tx_q[0..n-1] back-to-back with valid held high between bytes.
  task automatic run_seq(input int n);
    logic [7:0] rb;
    int rdy;
    wait_ready();
    valid_in = 1'b1;
    data_in  = tx_q[0];
    for (int b = 0; b < n; b++) begin
      rb  = '0;
      rdy = 0;
      for (int i = 0; i < 8; i++) begin
        step();
        if (i == 0) begin
          if (b + 1 < n) data_in = tx_q[b+1];
          else valid_in = 1'b0;
        end
        rb[7-i] = data_out;
        if (ready_out) rdy++;
      end
      check("seq_byte", rb, tx_q[b]);
      check("ready_per_slot", rdy, 1);
    end
  endtask

  initial begin
    logic [7:0] rb;
    reset    = 1'b1;
    valid_in = 1'b0;
    data_in  = 8'h00;
    for (int i = 0; i < 4; i++) step();
    check("rst_data", data_out, 1'b0);
    check("rst_ready", ready_out, 1'b0);
    check("rst_active", active_out, 1'b0);
    check("s1_rst_active", active1, 1'b0);
`ifdef PS_TX_BYTE_CNT_EN
    check("rst_byte_cnt", byte_cnt, 16'd0);
`endif
    reset = 1'b0;
    check_preamble();

    // Comma fill continues with no data offered.
    recv_byte(rb);
    check("idle_after_lock", rb, 8'hBC);

    tx_q[0] = 8'hA5;
    run_seq(1);
`ifdef PS_TX_BYTE_CNT_EN
    check("byte_cnt_one", byte_cnt, 16'd1);
`endif

    tx_q[0] = 8'h01;
    tx_q[1] = 8'h80;
    tx_q[2] = 8'hFF;
    run_seq(3);
`ifdef PS_TX_BYTE_CNT_EN
    check("byte_cnt_four", byte_cnt, 16'd4);
`endif

    // One-cycle valid pulse while ready is low must be ignored.
    step();
    rb[7] = data_out;
    check("ready_low_at_pulse", ready_out, 1'b0);
    valid_in = 1'b1;
    data_in  = 8'h55;
    step();
    valid_in = 1'b0;
    rb[6] = data_out;
    for (int i = 2; i < 8; i++) begin
      step();
      rb[7-i] = data_out;
    end
    check("pulse_slot_comma", rb, 8'hBC);
    recv_byte(rb);
    check("pulse_next_comma", rb, 8'hBC);
`ifdef PS_TX_BYTE_CNT_EN
    check("byte_cnt_unchanged", byte_cnt, 16'd4);
`endif

    // Reset in the middle of 8'h3C after bit 3 is on the line.
    wait_ready();
    valid_in = 1'b1;
    data_in  = 8'h3C;
    rb = '0;
    for (int i = 0; i < 4; i++) begin
      step();
      valid_in = 1'b0;
      rb[7-i] = data_out;
    end
    check("partial_3c", rb[7:4], 4'h3);
    reset = 1'b1;
    step();
    check("midrst_data", data_out, 1'b0);
    check("midrst_active", active_out, 1'b0);
    check("midrst_ready", ready_out, 1'b0);
    step();
    check("midrst_data_hold", data_out, 1'b0);
    reset = 1'b0;
    check_preamble();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
